mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage MIPS pipeline.
- Sequences each access through a req/ok handshake toward each stage and an en/ready handshake toward memory.
- Produces the stall requests the hazard logic uses to freeze F/D (fetch) or the whole pipe (data).
- Data has priority; an anti-starvation counter guarantees fetch progress.

---
 rtl/mips_defs.sv | 13 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS memory arbiter: FSM encoding and the
// read-data value returned when an access is aborted by the timeout.
package mips_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_D = 2'b01,
    BUSY_I = 2'b10
  } arbState_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage and the MEM stage.
// Data has priority; a streak counter guarantees fetch progress.
module mem_arbiter
  import mips_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  arbState_t     state, stateNext;
  logic [SW-1:0] streak, streakNext;
  logic [TW-1:0] toCount, toCountNext;
  logic          memEnNext, memWeNext, instOkNext, dataOkNext, busErrNext;
  logic [31:0]   memAddrNext, memWdataNext, instRdataNext, dataRdataNext;
  logic          instElig, dataElig, grantData, grantInst;

  assign stall_if  = inst_req & ~inst_ok;
  assign stall_mem = data_req & ~data_ok;

  // The ok cycle consumes the request, so a still-high req is not re-granted.
  assign instElig  = inst_req & ~inst_ok;
  assign dataElig  = data_req & ~data_ok;
  assign grantData = dataElig & (~instElig | (streak != STREAK_MAX));
  assign grantInst = instElig & ~grantData;

  always_comb begin
    stateNext     = state;
    streakNext    = streak;
    toCountNext   = toCount;
    memEnNext     = mem_en;
    memWeNext     = mem_we;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    instOkNext    = 1'b0;
    dataOkNext    = 1'b0;
    instRdataNext = inst_rdata;
    dataRdataNext = data_rdata;
    busErrNext    = bus_err;
    unique case (state)
      IDLE: begin
        if (grantData) begin
          stateNext    = BUSY_D;
          memEnNext    = 1'b1;
          memWeNext    = data_wr;
          memAddrNext  = data_addr;
          memWdataNext = data_wdata;
          toCountNext  = '0;
          streakNext   = (streak == STREAK_MAX) ? streak : streak + 1'b1;
        end else if (grantInst) begin
          stateNext   = BUSY_I;
          memEnNext   = 1'b1;
          memWeNext   = 1'b0;
          memAddrNext = inst_addr;
          toCountNext = '0;
          streakNext  = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (mem_ready) begin
          stateNext = IDLE;
          memEnNext = 1'b0;
          memWeNext = 1'b0;
          if (state == BUSY_D) begin
            dataOkNext = 1'b1;
            if (!mem_we) dataRdataNext = mem_rdata;
          end else begin
            instOkNext    = 1'b1;
            instRdataNext = mem_rdata;
          end
        end else if (toCount == TO_LAST) begin
          // Abort: complete the handshake with a dummy word and flag the error.
          stateNext  = IDLE;
          memEnNext  = 1'b0;
          memWeNext  = 1'b0;
          busErrNext = 1'b1;
          if (state == BUSY_D) begin
            dataOkNext    = 1'b1;
            dataRdataNext = TIMEOUT_RDATA;
          end else begin
            instOkNext    = 1'b1;
            instRdataNext = TIMEOUT_RDATA;
          end
        end else begin
          toCountNext = toCount + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      streak     <= '0;
      toCount    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      state      <= stateNext;
      streak     <= streakNext;
      toCount    <= toCountNext;
      mem_en     <= memEnNext;
      mem_we     <= memWeNext;
      mem_addr   <= memAddrNext;
      mem_wdata  <= memWdataNext;
      inst_ok    <= instOkNext;
      data_ok    <= dataOkNext;
      inst_rdata <= instRdataNext;
      data_rdata <= dataRdataNext;
      bus_err    <= busErrNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: drivers push expected responses,
// a negedge monitor checks completions, grants and stall outputs.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk, rst;
  logic        inst_req, inst_ok, data_req, data_wr, data_ok;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic        mem_en, mem_we, mem_ready, stall_if, stall_mem, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference memory: written words plus a deterministic fill for untouched ones.
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] memArr[logic [31:0]];
  logic [31:0] instExp[$];
  logic [31:0] dataExp[$];
  logic [31:0] refLast;
  int          respMode;  // 0 random waits, 1 zero wait, 2 never ready

  function automatic logic [31:0] fillWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : fillWord(a);
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : fillWord(a);
  endfunction

  // Memory model: random wait states, spurious mem_ready while idle.
  initial begin : responder
    int waits;
    bit active;
    mem_ready = 1'b0;
    mem_rdata = '0;
    active    = 1'b0;
    waits     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (!active) begin
          active = 1'b1;
          waits  = (respMode == 0) ? int'($urandom_range(0, 3)) : 0;
        end
        if (respMode == 2) begin
          mem_ready = 1'b0;
        end else if (waits == 0) begin
          mem_ready = 1'b1;
          mem_rdata = memRead(mem_addr);
          if (mem_we) memArr[mem_addr] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          waits--;
        end
      end else begin
        active    = 1'b0;
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: scoreboard pops, stall outputs, grant decisions and hold behaviour.
  bit          pValid, pEn, pEligI, pEligD, pDWr, wantD, wantI;
  logic [31:0] pIAddr, pDAddr, pDWdata, pAddr, pWdata;
  logic        pWe;
  int          dataRun;  // data grants since the last fetch grant

  always @(negedge clk) begin
    if (!rst) begin
      pValid  = 1'b0;
      dataRun = 0;
    end else begin
      if (inst_ok) begin
        if (instExp.size() == 0) check("inst_ok_unexpected", 32'(inst_ok), 32'd0);
        else begin
          $display("inst done rdata=%h", inst_rdata);
          check("inst_rdata", inst_rdata, instExp.pop_front());
        end
      end
      if (data_ok) begin
        if (dataExp.size() == 0) check("data_ok_unexpected", 32'(data_ok), 32'd0);
        else begin
          $display("data done rdata=%h", data_rdata);
          check("data_rdata", data_rdata, dataExp.pop_front());
        end
      end
      check("stall_if", 32'(stall_if), 32'(inst_req && !inst_ok));
      check("stall_mem", 32'(stall_mem), 32'(data_req && !data_ok));
      if (pValid && !pEn) begin
        if (pEligD && pEligI) begin
          wantD = (dataRun < STARVE);
          wantI = !wantD;
        end else begin
          wantD = pEligD;
          wantI = pEligI;
        end
        check("grant_en", 32'(mem_en), 32'(wantD || wantI));
        if (mem_en && wantD) begin
          check("grant_d_addr", mem_addr, pDAddr);
          check("grant_d_we", 32'(mem_we), 32'(pDWr));
          if (pDWr) check("grant_d_wdata", mem_wdata, pDWdata);
          dataRun++;
        end else if (mem_en && wantI) begin
          check("grant_i_addr", mem_addr, pIAddr);
          check("grant_i_we", 32'(mem_we), 32'd0);
          dataRun = 0;
        end
      end else if (pValid && pEn && mem_en) begin
        check("hold_addr", mem_addr, pAddr);
        check("hold_we", 32'(mem_we), 32'(pWe));
        check("hold_wdata", mem_wdata, pWdata);
      end
      pEn     = mem_en;
      pEligI  = inst_req && !inst_ok;
      pEligD  = data_req && !data_ok;
      pIAddr  = inst_addr;
      pDAddr  = data_addr;
      pDWr    = data_wr;
      pDWdata = data_wdata;
      pAddr   = mem_addr;
      pWe     = mem_we;
      pWdata  = mem_wdata;
      pValid  = 1'b1;
    end
  end

  task automatic waitOk(input bit isData, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(isData ? data_ok : inst_ok) && n < 300);
    check(isData ? "data_ok_seen" : "inst_ok_seen", 32'(isData ? data_ok : inst_ok), 32'd1);
  endtask

  task automatic instDriver(input int count);
    int n, w;
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      a = 32'h0000_0400 + 32'(4 * $urandom_range(0, 63));
      inst_addr = a;
      inst_req  = 1'b1;
      instExp.push_back(refRead(a));
      waitOk(1'b0, n);
      w = $urandom_range(0, 2);
      if (w != 0) begin
        inst_req = 1'b0;
        repeat (w) begin @(posedge clk); #1; end
      end
    end
    inst_req = 1'b0;
  endtask

  task automatic dataDriver(input int count);
    int n, w;
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      a          = 32'h1000_0000 + 32'(4 * $urandom_range(0, 15));
      data_wr    = 1'($urandom_range(0, 1));
      data_addr  = a;
      data_wdata = $urandom;
      data_req   = 1'b1;
      if (data_wr) begin
        dataExp.push_back(refLast);
        refMem[a] = data_wdata;
      end else begin
        refLast = refRead(a);
        dataExp.push_back(refLast);
      end
      waitOk(1'b1, n);
      w = $urandom_range(0, 1);
      if (w != 0) begin
        data_req = 1'b0;
        repeat (w) begin @(posedge clk); #1; end
      end
    end
    data_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    int n;
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0;
    respMode = 1;
    refLast  = '0;
    refMem[32'h40]  = 32'h2008_0005; memArr[32'h40]  = 32'h2008_0005;
    refMem[32'h100] = 32'h0000_1234; memArr[32'h100] = 32'h0000_1234;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_ok", 32'({inst_ok, data_ok}), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait fetch: grant on the first edge, ok on the second.
    inst_addr = 32'h40;
    inst_req  = 1'b1;
    instExp.push_back(refRead(32'h40));
    @(posedge clk);
    #1;
    check("fetch_c1_mem_en", 32'(mem_en), 32'd1);
    check("fetch_c1_mem_addr", mem_addr, 32'h40);
    check("fetch_c1_stall_if", 32'(stall_if), 32'd1);
    waitOk(1'b0, n);
    check("fetch_ok_cycle", 32'(n), 32'd1);
    check("fetch_c2_stall_if", 32'(stall_if), 32'd0);
    inst_req = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous fetch and load: data first, fetch after the idle gap.
    inst_addr = 32'h44;
    inst_req  = 1'b1;
    instExp.push_back(refRead(32'h44));
    data_addr = 32'h100;
    data_wr   = 1'b0;
    data_req  = 1'b1;
    refLast   = refRead(32'h100);
    dataExp.push_back(refLast);
    fork
      begin : dSide int m; waitOk(1'b1, m); data_req = 1'b0; end
      begin : iSide int m; waitOk(1'b0, m); inst_req = 1'b0; end
    join

    respMode = 0;
    fork
      instDriver(40);
      dataDriver(40);
    join
    check("bus_err_clean", 32'(bus_err), 32'd0);

    // Timeout: memory never answers a load.
    repeat (2) @(posedge clk);
    #1;
    respMode  = 2;
    data_addr = 32'h1000_0040;
    data_wr   = 1'b0;
    data_req  = 1'b1;
    refLast   = 32'h0;
    dataExp.push_back(32'h0);
    waitOk(1'b1, n);
    data_req = 1'b0;
    check("timeout_latency", 32'(n), 32'd9);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the middle of a stalled store.
    data_addr  = 32'h1000_0044;
    data_wr    = 1'b1;
    data_wdata = 32'hCAFE_F00D;
    data_req   = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_mem_en", 32'(mem_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mem_en", 32'(mem_en), 32'd0);
    check("async_rst_ok", 32'({inst_ok, data_ok}), 32'd0);
    check("async_rst_bus_err", 32'(bus_err), 32'd0);
    data_req = 1'b0;
    refLast  = 32'h0;
    respMode = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    fork
      instDriver(4);
      dataDriver(4);
    join
    repeat (3) @(posedge clk);
    #1;
    check("inst_queue_drained", 32'(instExp.size()), 32'd0);
    check("data_queue_drained", 32'(dataExp.size()), 32'd0);
    check("final_bus_err", 32'(bus_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
